// File: rtl/matrix_stream_loader.sv
// matrix_stream_loader
// Packs a byte stream row-major into the 5x5 flattened matrix word used by
// the MPU and writes each finished matrix to consecutive memory addresses.
// Element (r,c) of an NxN matrix lands at bits [(r*DIM+c)*DATA_W +: DATA_W];
// positions outside the active NxN region are zero.
//
// Ports:
//   clock      - system clock, rising-edge active
//   reset_n    - asynchronous active-low reset
//   start      - single-cycle job request, honoured only when idle
//   size       - active dimension N (2..DIM), sampled on accepted start
//   base_addr  - first write address, sampled on accepted start
//   num_mats   - matrices in the job (0 finishes at once), sampled on start
//   in_valid   - in_data holds an element
//   in_data    - element byte
//   in_ready   - loader accepts an element this cycle (from state only)
//   mem_wren   - memory write enable (one cycle per matrix)
//   mem_addr   - memory write address (holds between writes)
//   mem_data   - packed matrix word (holds between writes)
//   busy       - job in progress
//   done       - one-cycle pulse at job completion
//   error      - one-cycle pulse when a start carries an invalid size
module matrix_stream_loader #(
  parameter int DATA_W = 8,
  parameter int DIM    = 5,
  parameter int ADDR_W = 3
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [2:0]               size,
  input  logic [ADDR_W-1:0]        base_addr,
  input  logic [ADDR_W-1:0]        num_mats,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     in_ready,
  output logic                     mem_wren,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DIM*DIM*DATA_W-1:0] mem_data,
  output logic                     busy,
  output logic                     done,
  output logic                     error
);

  localparam int CELLS  = DIM * DIM;
  localparam int WORD_W = CELLS * DATA_W;
  localparam int IDX_W  = $clog2(CELLS);
  // Row/column counters match the width of the size port.
  localparam int RC_W   = 3;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE, S_DONE} state_t;

  state_t              state_reg, state_next;
  logic [2:0]          size_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [ADDR_W-1:0]   num_reg;
  logic [ADDR_W-1:0]   count_reg;
  logic [RC_W-1:0]     row_reg;
  logic [RC_W-1:0]     col_reg;
  logic [WORD_W-1:0]   buf_reg;
  logic [WORD_W-1:0]   buf_next;
  logic [WORD_W-1:0]   mem_data_reg;
  logic [ADDR_W-1:0]   mem_addr_reg;
  logic                done_reg;
  logic                error_reg;

  logic                size_ok;
  logic                start_ok;
  logic                start_bad;
  logic                accept;
  logic [2:0]          last_rc;
  logic                col_last;
  logic                row_last;
  logic                mat_last;
  logic [ADDR_W-1:0]   count_inc;
  logic                job_last;
  logic [IDX_W-1:0]    idx;

  assign size_ok   = (size >= 3'd2) && (size <= 3'(DIM));
  assign start_ok  = (state_reg == S_IDLE) && start && size_ok;
  assign start_bad = (state_reg == S_IDLE) && start && !size_ok;
  assign accept    = in_valid && in_ready;
  assign last_rc   = size_reg - 3'd1;
  assign col_last  = (col_reg == last_rc);
  assign row_last  = (row_reg == last_rc);
  assign mat_last  = accept && col_last && row_last;
  assign count_inc = count_reg + ADDR_W'(1);
  assign job_last  = (count_inc == num_reg);
  assign idx       = IDX_W'(row_reg) * IDX_W'(DIM) + IDX_W'(col_reg);

  // Buffer image including the byte being accepted this cycle; the final
  // byte of a matrix goes straight into the output register through this.
  generate
    for (genvar gi = 0; gi < CELLS; gi++) begin : g_cell
      assign buf_next[gi*DATA_W +: DATA_W] =
        (accept && (idx == IDX_W'(gi))) ? in_data : buf_reg[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (start_ok) begin
          state_next = (num_mats == '0) ? S_DONE : S_FILL;
        end
      end
      S_FILL: begin
        if (mat_last) begin
          state_next = S_WRITE;
        end
      end
      S_WRITE: begin
        state_next = job_last ? S_DONE : S_FILL;
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State-decoded outputs
  always_comb begin
    in_ready = 1'b0;
    mem_wren = 1'b0;
    busy     = 1'b0;
    case (state_reg)
      S_FILL:  begin in_ready = 1'b1; busy = 1'b1; end
      S_WRITE: begin mem_wren = 1'b1; busy = 1'b1; end
      S_DONE:  begin busy = 1'b1; end
      default: begin end
    endcase
  end

  // Datapath: job parameters, counters, pack buffer and output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      size_reg     <= '0;
      addr_reg     <= '0;
      num_reg      <= '0;
      count_reg    <= '0;
      row_reg      <= '0;
      col_reg      <= '0;
      buf_reg      <= '0;
      mem_data_reg <= '0;
      mem_addr_reg <= '0;
      done_reg     <= 1'b0;
      error_reg    <= 1'b0;
    end else begin
      done_reg  <= (state_reg == S_DONE);
      error_reg <= start_bad;
      case (state_reg)
        S_IDLE: begin
          if (start_ok) begin
            size_reg  <= size;
            addr_reg  <= base_addr;
            num_reg   <= num_mats;
            count_reg <= '0;
            row_reg   <= '0;
            col_reg   <= '0;
            buf_reg   <= '0;
          end
        end
        S_FILL: begin
          if (accept) begin
            buf_reg <= buf_next;
            if (col_last) begin
              col_reg <= '0;
              row_reg <= row_reg + RC_W'(1);
            end else begin
              col_reg <= col_reg + RC_W'(1);
            end
            // Capture the complete matrix so it is presented during WRITE
            // and held afterwards while the buffer refills.
            if (mat_last) begin
              mem_data_reg <= buf_next;
              mem_addr_reg <= addr_reg;
            end
          end
        end
        S_WRITE: begin
          addr_reg  <= addr_reg + ADDR_W'(1);
          count_reg <= count_inc;
          row_reg   <= '0;
          col_reg   <= '0;
          buf_reg   <= '0;
        end
        default: begin end
      endcase
    end
  end

  assign mem_addr = mem_addr_reg;
  assign mem_data = mem_data_reg;
  assign done     = done_reg;
  assign error    = error_reg;

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Testbench for matrix_stream_loader: directed scenarios plus randomized jobs,
// checked against a queue-based reference model of the expected writes.
module tb_matrix_stream_loader;

  localparam int DATA_W = 8;
  localparam int DIM    = 5;
  localparam int ADDR_W = 3;
  localparam int WORD_W = DIM * DIM * DATA_W;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [2:0]        size = '0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W-1:0] num_mats = '0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready;
  logic              mem_wren;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_data;
  logic              busy;
  logic              done;
  logic              error;

  matrix_stream_loader #(.DATA_W(DATA_W), .DIM(DIM), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .size(size),
    .base_addr(base_addr), .num_mats(num_mats), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .mem_wren(mem_wren),
    .mem_addr(mem_addr), .mem_data(mem_data), .busy(busy), .done(done),
    .error(error)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model state
  int                job_n = 2;
  int                job_base = 0;
  int                mat_idx = 0;
  int                k = 0;
  int                mats_left = 0;
  int                acc_total = 0;
  int                complete_edge = -10;
  int                exp_done_cyc = -10;
  bit                job_active = 1'b0;
  logic [WORD_W-1:0] cur_word = '0;
  logic [WORD_W-1:0] last_word = '0;
  logic [ADDR_W-1:0] last_addr = '0;
  logic [WORD_W-1:0] exp_data_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$];

  task automatic check_eq(input string tag, input logic [WORD_W-1:0] got,
                          input logic [WORD_W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // Model: every accepted byte k of an NxN matrix goes to row k/N, col k%N.
  always @(posedge clock) begin
    cyc++;
    if (reset_n && in_valid && in_ready) begin
      acc_total++;
      cur_word[((k / job_n) * DIM + (k % job_n)) * DATA_W +: DATA_W] = in_data;
      k++;
      if (k == job_n * job_n) begin
        exp_data_q.push_back(cur_word);
        exp_addr_q.push_back(ADDR_W'((job_base + mat_idx) % (1 << ADDR_W)));
        mat_idx++;
        k = 0;
        cur_word = '0;
        complete_edge = cyc;
      end
    end
  end

  // Per-cycle output checks
  always @(negedge clock) begin
    bit exp_wren;
    exp_wren = reset_n && (complete_edge == cyc);
    check_eq("wren", WORD_W'(mem_wren), WORD_W'(exp_wren));
    if (exp_wren && exp_addr_q.size() > 0) begin
      last_addr = exp_addr_q.pop_front();
      last_word = exp_data_q.pop_front();
      check_eq("wr_addr", WORD_W'(mem_addr), WORD_W'(last_addr));
      check_eq("wr_data", mem_data, last_word);
      check_eq("ready_in_write", WORD_W'(in_ready), '0);
      mats_left--;
      if (mats_left == 0) exp_done_cyc = cyc + 2;
    end else begin
      check_eq("hold_addr", WORD_W'(mem_addr), WORD_W'(last_addr));
      check_eq("hold_data", mem_data, last_word);
    end
    check_eq("done", WORD_W'(done), WORD_W'(cyc == exp_done_cyc));
    if (cyc == exp_done_cyc) begin
      check_eq("busy_at_done", WORD_W'(busy), '0);
      job_active = 1'b0;
    end
    if (!job_active) check_eq("ready_idle", WORD_W'(in_ready), '0);
  end

  task automatic do_start(input int n, input int base, input int num);
    bit ok;
    ok = (n >= 2) && (n <= DIM);
    @(negedge clock);
    start = 1'b1;
    size = 3'(n);
    base_addr = ADDR_W'(base);
    num_mats = ADDR_W'(num);
    if (ok) begin
      job_n = n;
      job_base = base;
      mat_idx = 0;
      k = 0;
      cur_word = '0;
      mats_left = num;
      job_active = (num != 0);
      if (num == 0) exp_done_cyc = cyc + 2;
    end
    @(negedge clock);
    start = 1'b0;
    check_eq("error", WORD_W'(error), WORD_W'(!ok));
    check_eq("busy_after_start", WORD_W'(busy), WORD_W'(ok));
    if (!ok) begin
      @(negedge clock);
      check_eq("error_pulse", WORD_W'(error), '0);
      check_eq("busy_rejected", WORD_W'(busy), '0);
    end
  endtask

  // mode 0: continuous valid, 1: toggling valid, 2: random gaps.
  // seq_base >= 0 gives seq_base, seq_base+1, ...; otherwise hashed bytes.
  task automatic feed(input int total, input int mode, input int seq_base);
    int base_acc;
    int guard;
    int idx;
    int salt;
    base_acc = acc_total;
    guard = 0;
    salt = int'($urandom_range(0, 255));
    while ((acc_total - base_acc) < total && guard < 3000) begin
      @(negedge clock);
      guard++;
      idx = acc_total - base_acc;
      if (idx >= total) begin
        in_valid = 1'b0;
      end else begin
        case (mode)
          0:       in_valid = 1'b1;
          1:       in_valid = guard[0];
          default: in_valid = ($urandom_range(0, 3) != 0);
        endcase
        in_data = (seq_base >= 0) ? DATA_W'(seq_base + idx) : DATA_W'(salt + idx * 73);
      end
    end
    in_valid = 1'b0;
    check_eq("feed_count", WORD_W'(acc_total - base_acc), WORD_W'(total));
  endtask

  task automatic wait_done();
    int g;
    g = 0;
    while (done !== 1'b1 && g < 200) begin
      @(negedge clock);
      g++;
    end
    check_eq("done_seen", WORD_W'(done), WORD_W'(1));
    @(negedge clock);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, b, m, mode;
    repeat (2) @(negedge clock);
    check_eq("rst_in_ready", WORD_W'(in_ready), '0);
    check_eq("rst_mem_wren", WORD_W'(mem_wren), '0);
    check_eq("rst_busy", WORD_W'(busy), '0);
    check_eq("rst_done", WORD_W'(done), '0);
    check_eq("rst_error", WORD_W'(error), '0);
    check_eq("rst_mem_addr", WORD_W'(mem_addr), '0);
    check_eq("rst_mem_data", mem_data, '0);
    #2 reset_n = 1'b1;

    // N=2 single matrix, continuous valid
    do_start(2, 1, 1);
    feed(4, 0, 1);
    wait_done();

    // N=3 two matrices, toggling valid
    do_start(3, 0, 2);
    feed(18, 1, 1);
    wait_done();

    // N=5 two matrices with address wrap 7 -> 0
    do_start(5, 7, 2);
    feed(50, 0, 0);
    wait_done();

    // Invalid sizes
    do_start(1, 0, 1);
    do_start(6, 0, 1);
    do_start(0, 2, 3);
    do_start(7, 4, 2);

    // Empty job
    do_start(2, 3, 0);
    wait_done();

    // N=4 job aborted by reset after 10 bytes, with an ignored start mid-job
    do_start(4, 2, 1);
    feed(5, 0, 0);
    @(negedge clock);
    start = 1'b1; size = 3'd2; base_addr = 3'd5; num_mats = 3'd1;
    @(negedge clock);
    start = 1'b0;
    feed(5, 2, 100);
    #3 reset_n = 1'b0;
    #1;
    check_eq("abort_ready", WORD_W'(in_ready), '0);
    check_eq("abort_busy", WORD_W'(busy), '0);
    k = 0;
    cur_word = '0;
    complete_edge = -10;
    exp_done_cyc = -10;
    mats_left = 0;
    job_active = 1'b0;
    exp_addr_q.delete();
    exp_data_q.delete();
    last_addr = '0;
    last_word = '0;
    repeat (2) @(negedge clock);
    check_eq("abort_mem_addr", WORD_W'(mem_addr), '0);
    check_eq("abort_mem_data", mem_data, '0);
    #2 reset_n = 1'b1;
    do_start(2, 6, 1);
    feed(4, 2, -1);
    wait_done();

    // Randomized jobs
    repeat (8) begin
      n = int'($urandom_range(2, 5));
      b = int'($urandom_range(0, 7));
      m = int'($urandom_range(1, 3));
      mode = int'($urandom_range(0, 2));
      do_start(n, b, m);
      feed(n * n * m, mode, -1);
      wait_done();
    end

    repeat (3) @(negedge clock);
    check_eq("queue_empty", WORD_W'(exp_addr_q.size()), '0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
